// File: rtl/second_game_field.sv
// second_game_field: scrolling obstacle map, player square and
// run/crash FSM for the second game; state advances once per frame tick.
module second_game_field #(
    parameter int          SCREEN_WIDTH   = 400,
    parameter int          SCREEN_HEIGHT  = 600,
    parameter int          PLAYER_SIZE    = 20,
    parameter int          PLAYER_START_Y = 540,
    parameter int          PLAYER_STEP    = 4,
    parameter int          CELL_LOG2      = 5,
    parameter int          SCROLL_STEP    = 2,
    parameter int          CRASH_FRAMES   = 60,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int         XW             = $clog2(SCREEN_WIDTH),
    localparam int         YW             = $clog2(SCREEN_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_frame_tick,
    input  logic          i_start,
    input  logic          i_left,
    input  logic          i_right,
    input  logic [XW-1:0] i_screen_x,
    input  logic [YW-1:0] i_screen_y,
    output logic          o_is_obstacle,
    output logic [XW-1:0] o_square_x,
    output logic [YW-1:0] o_square_y,
    output logic          o_playing,
    output logic          o_game_over,
    output logic [15:0]   o_score
);
    localparam int CELL = 1 << CELL_LOG2;
    localparam int COLS = (SCREEN_WIDTH + CELL - 1) / CELL;
    localparam int ROWS = (SCREEN_HEIGHT + CELL - 1) / CELL + 1;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int CFW  = $clog2(CRASH_FRAMES);
    localparam int SW   = CELL_LOG2;
    localparam int QW   = YW + 2 - CELL_LOG2;
    localparam int PW   = XW + 1 - CELL_LOG2;

    localparam logic [XW:0]    X_MIN   = (XW+1)'(PLAYER_SIZE);
    localparam logic [XW:0]    X_MAX   = (XW+1)'(SCREEN_WIDTH - 1 - PLAYER_SIZE);
    localparam logic [XW:0]    X_STEP  = (XW+1)'(PLAYER_STEP);
    localparam logic [XW:0]    X_HALF  = (XW+1)'(PLAYER_SIZE);
    localparam logic [YW:0]    Y_HALF  = (YW+1)'(PLAYER_SIZE);
    localparam logic [XW-1:0]  X_MID   = XW'(SCREEN_WIDTH / 2);
    localparam logic [YW-1:0]  Y_START = YW'(PLAYER_START_Y);
    localparam logic [CFW-1:0] C_LAST  = CFW'(CRASH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_CRASH
    } state_t;

    typedef logic [ROWS-1:0][COLS-1:0] map_t;

    state_t         state;
    map_t           map;
    logic [SW-1:0]  scroll_off;
    logic [XW-1:0]  square_x;
    logic [15:0]    score;
    logic [15:0]    lfsr;
    logic           row_toggle;
    logic [CFW-1:0] crash_cnt;

    // Row = (y + CELL - scroll) / CELL; row 0 stays above screen until scrolled in.
    function automatic logic lookup(
        input logic [XW:0]   x,
        input logic [YW:0]   y,
        input map_t          m,
        input logic [SW-1:0] s
    );
        logic [YW+1:0] ys;
        logic [XW:0]   col;
        logic [YW+1:0] row;
        ys  = {1'b0, y} + (YW+2)'(CELL) - (YW+2)'(s);
        col = x >> CELL_LOG2;
        row = ys >> CELL_LOG2;
        if (col >= (XW+1)'(COLS) || row >= (YW+2)'(ROWS))
            return 1'b0;
        return m[row[RW-1:0]][col[CW-1:0]];
    endfunction

    logic [XW:0]     cx_lo, cx_hi, x_next;
    logic [YW:0]     cy_lo, cy_hi;
    logic            hit;
    logic [SW:0]     scroll_sum;
    logic            wrap;
    logic [COLS-1:0] new_row;
    logic            lfsr_fb;

    always_comb begin
        cx_lo = {1'b0, square_x} - X_HALF;
        cx_hi = {1'b0, square_x} + X_HALF;
        cy_lo = {1'b0, Y_START} - Y_HALF;
        cy_hi = {1'b0, Y_START} + Y_HALF;
        hit   = lookup(cx_lo, cy_lo, map, scroll_off)
              | lookup(cx_hi, cy_lo, map, scroll_off)
              | lookup(cx_lo, cy_hi, map, scroll_off)
              | lookup(cx_hi, cy_hi, map, scroll_off);
    end

    always_comb begin
        x_next = {1'b0, square_x};
        if (i_right && !i_left)
            x_next = (x_next + X_STEP > X_MAX) ? X_MAX : x_next + X_STEP;
        else if (i_left && !i_right)
            x_next = (x_next < X_MIN + X_STEP) ? X_MIN : x_next - X_STEP;
    end

    // scroll_off < CELL, so the carry bit alone marks a new row.
    assign scroll_sum = {1'b0, scroll_off} + (SW+1)'(SCROLL_STEP);
    assign wrap       = scroll_sum[SW];
    assign new_row    = row_toggle ? (lfsr[COLS-1:0] & lfsr[15:16-COLS]) : '0;
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            map        <= '0;
            scroll_off <= '0;
            square_x   <= X_MID;
            score      <= '0;
            lfsr       <= LFSR_SEED;
            row_toggle <= 1'b0;
            crash_cnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state      <= S_PLAY;
                        map        <= '0;
                        score      <= '0;
                        scroll_off <= '0;
                        square_x   <= X_MID;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        state     <= S_CRASH;
                        crash_cnt <= '0;
                    end else if (i_frame_tick) begin
                        square_x   <= x_next[XW-1:0];
                        scroll_off <= scroll_sum[SW-1:0];
                        if (wrap) begin
                            map        <= {map[ROWS-2:0], new_row};
                            row_toggle <= ~row_toggle;
                            lfsr       <= {lfsr[14:0], lfsr_fb};
                            if (score != 16'hFFFF)
                                score <= score + 16'd1;
                        end
                    end
                end
                S_CRASH: begin
                    if (i_frame_tick) begin
                        if (crash_cnt == C_LAST)
                            state <= S_IDLE;
                        else
                            crash_cnt <= crash_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_is_obstacle = lookup({1'b0, i_screen_x}, {1'b0, i_screen_y},
                                  map, scroll_off);
    assign o_square_x    = square_x;
    assign o_square_y    = Y_START;
    assign o_playing     = (state == S_PLAY);
    assign o_game_over   = (state == S_CRASH);
    assign o_score       = score;

endmodule

// File: tb/tb_second_game_field.sv
// tb_second_game_field: random play of second_game_field against a
// frame-level model of map, player, score and run/crash state.
module tb_second_game_field;
    localparam int XW = $clog2(400);
    localparam int YW = $clog2(600);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_frame_tick = 1'b0;
    logic          i_start = 1'b0;
    logic          i_left = 1'b0;
    logic          i_right = 1'b0;
    logic [XW-1:0] i_screen_x = '0;
    logic [YW-1:0] i_screen_y = '0;
    logic          o_is_obstacle;
    logic [XW-1:0] o_square_x;
    logic [YW-1:0] o_square_y;
    logic          o_playing;
    logic          o_game_over;
    logic [15:0]   o_score;

    int checks = 0;
    int failures = 0;

    second_game_field dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_tick  (i_frame_tick),
        .i_start       (i_start),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_screen_x    (i_screen_x),
        .i_screen_y    (i_screen_y),
        .o_is_obstacle (o_is_obstacle),
        .o_square_x    (o_square_x),
        .o_square_y    (o_square_y),
        .o_playing     (o_playing),
        .o_game_over   (o_game_over),
        .o_score       (o_score)
    );

    always #5 i_clk = ~i_clk;

    // model: 0 idle, 1 play, 2 crash
    bit [12:0] mmap [20];
    int        mscroll, mx, mscore, mstate, mcc;
    bit [15:0] mlfsr;
    bit        mtog;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit m_lookup(input int x, input int y);
        int col, row;
        col = x / 32;
        row = (y + 32 - mscroll) / 32;
        if (col >= 13 || row >= 20) return 1'b0;
        return mmap[row][col];
    endfunction

    function automatic bit m_hit();
        return m_lookup(mx - 20, 520) || m_lookup(mx + 20, 520) ||
               m_lookup(mx - 20, 560) || m_lookup(mx + 20, 560);
    endfunction

    task automatic m_reset();
        foreach (mmap[i]) mmap[i] = '0;
        mscroll = 0; mx = 200; mscore = 0; mstate = 0; mcc = 0;
        mlfsr = 16'hACE1; mtog = 1'b0;
    endtask

    task automatic m_start();
        foreach (mmap[i]) mmap[i] = '0;
        mscroll = 0; mx = 200; mscore = 0; mstate = 1;
    endtask

    task automatic m_tick(input bit l, input bit r, input bit s);
        if (mstate == 0) begin
            if (s) m_start();
        end else if (mstate == 1) begin
            if (r && !l) mx = (mx + 4 > 379) ? 379 : mx + 4;
            else if (l && !r) mx = (mx - 4 < 20) ? 20 : mx - 4;
            mscroll += 2;
            if (mscroll >= 32) begin
                mscroll -= 32;
                for (int i = 19; i > 0; i--) mmap[i] = mmap[i-1];
                mmap[0] = mtog ? (mlfsr[12:0] & mlfsr[15:3]) : 13'd0;
                mtog = !mtog;
                mlfsr = {mlfsr[14:0],
                         mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
                if (mscore < 65535) mscore++;
            end
            if (m_hit()) begin
                mstate = 2;
                mcc = 0;
            end
        end else begin
            if (mcc == 59) mstate = 0;
            else mcc++;
        end
    endtask

    task automatic query(input string tag, input int x, input int y);
        i_screen_x = XW'(x);
        i_screen_y = YW'(y);
        #1;
        check(tag, 32'(o_is_obstacle), 32'(m_lookup(x, y)));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".x"}, 32'(o_square_x), 32'(mx));
        check({tag, ".y"}, 32'(o_square_y), 32'd540);
        check({tag, ".play"}, 32'(o_playing), 32'(mstate == 1));
        check({tag, ".over"}, 32'(o_game_over), 32'(mstate == 2));
        check({tag, ".score"}, 32'(o_score), 32'(mscore));
        query({tag, ".q1"}, int'($urandom_range(511)), int'($urandom_range(1023)));
        query({tag, ".q2"}, int'($urandom_range(415)), int'($urandom_range(100)));
    endtask

    // Tick edge, then one more edge for the collision to register.
    task automatic do_tick(input bit l, input bit r, input bit s,
                           input string tag);
        i_left = l; i_right = r; i_start = s; i_frame_tick = 1'b1;
        @(negedge i_clk);
        i_frame_tick = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        m_tick(l, r, s);
        check_all(tag);
    endtask

    task automatic do_start(input string tag);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        if (mstate == 0) m_start();
        check_all(tag);
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge i_clk);
        check("rst.x", 32'(o_square_x), 32'd200);
        check("rst.y", 32'(o_square_y), 32'd540);
        check("rst.play", 32'(o_playing), 32'd0);
        check("rst.over", 32'(o_game_over), 32'd0);
        check("rst.score", 32'(o_score), 32'd0);
        i_screen_x = '0; i_screen_y = '0; #1;
        check("rst.q00", 32'(o_is_obstacle), 32'd0);
        i_screen_x = XW'(399); i_screen_y = YW'(599); #1;
        check("rst.qmax", 32'(o_is_obstacle), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        do_start("start");
        for (int t = 1; t <= 33; t++) begin
            do_tick(1'b0, 1'b0, 1'b0, "idle_run");
            if (t == 16) check("score16", 32'(o_score), 32'd1);
            if (t == 32) check("score32", 32'(o_score), 32'd2);
        end
        for (int c = 0; c < 13; c++)
            for (int y = 0; y < 3; y++)
                query("row0", c * 32 + 7, y);

        repeat (60) do_tick(1'b0, 1'b1, 1'b0, "right");
        check("clamp_hi", 32'(o_square_x), 32'd379);
        repeat (100) do_tick(1'b1, 1'b0, 1'b0, "left");
        check("clamp_lo", 32'(o_square_x), 32'd20);
        repeat (10) do_tick(1'b0, 1'b1, 1'b0, "right2");
        repeat (3) do_tick(1'b1, 1'b1, 1'b0, "both");
        check("both_x", 32'(o_square_x), 32'd60);

        for (int t = 0; t < 4000 && mstate == 1; t++)
            do_tick(1'(($urandom & 3) == 1), 1'(($urandom & 3) == 2),
                    1'b0, "rand");

        if (mstate == 2) begin
            do_start("crash_start");
            for (int t = 1; t <= 60; t++) begin
                do_tick(1'($urandom), 1'($urandom), 1'($urandom), "crash");
                if (t == 59) check("crash59", 32'(o_game_over), 32'd1);
            end
            check("to_idle", 32'(o_playing | o_game_over), 32'd0);
            for (int k = 0; k < 30; k++)
                query("idle_map", int'($urandom_range(415)),
                      int'($urandom_range(639)));
        end

        do_tick(1'b1, 1'b0, 1'b1, "start_tick");
        check("st_x", 32'(o_square_x), 32'd200);
        check("st_play", 32'(o_playing), 32'd1);
        for (int t = 0; t < 40 && mstate == 1; t++)
            do_tick(1'($urandom), 1'($urandom), 1'b0, "run2");

        i_rst = 1'b1;
        @(negedge i_clk);
        m_reset();
        check_all("midrst");
        i_screen_x = '0; i_screen_y = '0; #1;
        check("midrst.q00", 32'(o_is_obstacle), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
